hub75_pattern_gen: RTL and testbench
====================================

# hub75_pattern_gen

Parametrised, animated test-pattern source for the HUB75 panel driver. It serves the same pixel read interface as a frame buffer, so the scan engine can be pointed at it in place of real video. It produces one RGB pixel per segment per read, with a fixed two-cycle latency. A mode is selected at frame boundaries, and a frame-driven animation counter moves the dynamic patterns.

## Interface
- hpixel_p, 64, panel width in pixels; power of two, ≥ 8
- vpixel_p, 64, panel height in lines; power of two
- bpp_p, 8, bits per colour channel; ≥ 1
- segments_p, 2, simultaneously driven segments; power of two dividing vpixel_p
- frame_div_p, 4, frame starts per animation step; power of two, ≥ 1
- Derived: seg_lines = vpixel_p/segments_p; addr_width = clog2(hpixel_p*seg_lines)

Ports:
- clk  in  1  clock; single clock domain
- rst_n  in  1  asynchronous active-low reset
- i_mode  in  3  requested pattern mode, sampled only on i_frame_start
- i_frame_start  in  1  one-cycle pulse at the start of each panel frame
- i_rd_en  in  1  read request
- i_rd_addr  in  addr_width  {line_in_segment, col}; col occupies the low clog2(hpixel_p) bits
- o_rd_data  out  segments_p×3×bpp_p  [seg][R,G,B] pixel data
- o_rd_valid  out  1  o_rd_data is valid

## Operation
- Global line for segment s = s*seg_lines + line_in_segment.
- Active mode register:
  - Loads i_mode on i_frame_start.
  - Reset value is OFF.
  - Never changes between frame starts.
- Prescaler (log2(frame_div_p) bits):
  - Increments on each i_frame_start.
  - On wrap, anim (8 bits, wraps 255→0) increments.
  - With frame_div_p=1, anim increments on every frame start.
- Scale rule, scale(v, w), maps a w-bit value to bpp_p bits MSB-aligned:
  - bpp_p ≥ w: {v, zeros}.
  - bpp_p < w: v[w-1 -: bpp_p].
  - FULL = all ones.
- Modes (hub75_pkg enum):
  - 0 OFF: all channels 0.
  - 1 WHITE: all channels FULL.
  - 2 BARS: bar = col[msb -: 3] (8 bars). R = FULL if bar[2]; G = FULL if bar[1]; B = FULL if bar[0]; otherwise 0.
  - 3 GRAD: R = scale(col), G = scale(global line), B = scale(anim, 8).
  - 4 CHECKER: 8×8 cells. on = col[3] ^ line[3] ^ anim[0]; all channels FULL if on, else 0.
  - 5 SCROLL: same as BARS, but uses col' = (col + anim) mod hpixel_p.
  - 6, 7 reserved: treated as OFF.

## Timing
- Pipeline:
  - Stage 1 registers the address, the per-segment global lines, the active mode and anim.
  - Stage 2 registers o_rd_data.
  - Latency is 2 cycles: a read in cycle N appears in N+2.
  - o_rd_valid = i_rd_en delayed 2 cycles.
  - A read is accepted every cycle; there is no backpressure.
- When i_rd_en=0:
  - The pipeline still advances.
  - o_rd_data holds its last value.
- i_frame_start and i_rd_en in the same cycle:
  - That read uses the old mode and old anim.
  - New values apply from the next cycle's reads.
- i_mode changes without i_frame_start have no effect.
- Reset:
  - Asynchronous assertion at any time clears o_rd_data, o_rd_valid, the pipeline, the mode register, the prescaler and anim.
  - Reads in flight are dropped, with no valid pulse.
  - After release, the first valid output arrives 2 cycles after the first i_rd_en.

## Structure
- hub75_pkg holds:
  - the mode_e enum (OFF, WHITE, BARS, GRAD, CHECKER, SCROLL);
  - the scale function;
  - the bar count constant (8) and checker cell log2 (3).
- Sub-module hub75_pattern_pixel:
  - Combinational mapping of (mode, col, global line, anim) to one RGB pixel.
  - Instantiated once per segment in a generate loop.
- The top level holds the mode register, prescaler/anim counter, pipeline registers and valid shift.

## Test plan
All scenarios use the default parameters.
- Reset: hold rst_n=0, then release. o_rd_data=0 and o_rd_valid=0. With i_rd_en high, valid first asserts exactly 2 cycles after the first read.
- BARS: send a frame start with i_mode=2, then read col=8, line=0. Two cycles later, both segments show R=0x00, G=0x00, B=0xFF. A read at col=63 gives all channels 0xFF.
- GRAD: after 4 frame starts (anim=1), read line_in_seg=5, col=63. Segment 1 gives R=0xFC, G=0x94 (line 37), B=0x01. Segment 0 gives G=0x14.
- Mode gating: with i_mode changed to 1 without a frame start, reads stay in the old mode. A frame start pulse coincident with a read leaves that read in the old mode; the next read is WHITE.
- SCROLL and CHECKER:
  - SCROLL at anim=1: col=7 yields bar 1 (B=0xFF).
  - After 256×4 frame starts, anim wraps to 0.
  - CHECKER at col=8, line=0, anim=0 yields all 0xFF.
- Reset mid-stream: assert rst_n low with two reads in flight. No o_rd_valid pulse follows, the mode returns to OFF and anim returns to 0.

Source files
------------

// File: rtl/hub75_pkg.sv
// Shared definitions for the HUB75 test-pattern source: pattern modes, geometry
// constants and the MSB-aligned channel scaling helper.
package hub75_pkg;

  typedef enum logic [2:0] {
    OFF     = 3'd0,
    WHITE   = 3'd1,
    BARS    = 3'd2,
    GRAD    = 3'd3,
    CHECKER = 3'd4,
    SCROLL  = 3'd5
  } mode_e;

  localparam int bar_count_lp    = 8;
  localparam int checker_log2_lp = 3;

  // Maps a w-bit value onto bpp bits, MSB-aligned; the caller keeps the low bpp bits.
  function automatic logic [31:0] scale(input logic [31:0] v, input int w, input int bpp);
    if (bpp >= w) return v << (bpp - w);
    return v >> (w - bpp);
  endfunction

endpackage

// File: rtl/hub75_pattern_pixel.sv
// Combinational pattern lookup: (mode, column, global line, anim) -> one RGB pixel.
module hub75_pattern_pixel
  import hub75_pkg::*;
#(
  parameter int bpp_p    = 8,
  parameter int col_w_p  = 6,
  parameter int line_w_p = 6
) (
  input  mode_e               mode,
  input  logic [col_w_p-1:0]  col,
  input  logic [line_w_p-1:0] line,
  input  logic [7:0]          anim,
  output logic [bpp_p-1:0]    r,
  output logic [bpp_p-1:0]    g,
  output logic [bpp_p-1:0]    b
);

  localparam int bar_w_lp = $clog2(bar_count_lp);

  logic [col_w_p-1:0]  scroll_col;
  logic [bar_w_lp-1:0] bar;
  logic [bar_w_lp-1:0] scroll_bar;
  logic                checker_on;

  // Truncating anim to the column width gives the wrap modulo the panel width.
  assign scroll_col = col + col_w_p'(anim);
  assign bar        = bar_w_lp'(col >> (col_w_p - bar_w_lp));
  assign scroll_bar = bar_w_lp'(scroll_col >> (col_w_p - bar_w_lp));
  assign checker_on = (|((32'(col) ^ 32'(line)) & (32'd1 << checker_log2_lp))) ^ anim[0];

  always_comb begin
    r = '0;
    g = '0;
    b = '0;
    case (mode)
      WHITE: begin
        r = '1;
        g = '1;
        b = '1;
      end
      BARS: begin
        r = {bpp_p{bar[2]}};
        g = {bpp_p{bar[1]}};
        b = {bpp_p{bar[0]}};
      end
      GRAD: begin
        r = bpp_p'(scale(32'(col), col_w_p, bpp_p));
        g = bpp_p'(scale(32'(line), line_w_p, bpp_p));
        b = bpp_p'(scale(32'(anim), 8, bpp_p));
      end
      CHECKER: begin
        r = {bpp_p{checker_on}};
        g = {bpp_p{checker_on}};
        b = {bpp_p{checker_on}};
      end
      SCROLL: begin
        r = {bpp_p{scroll_bar[2]}};
        g = {bpp_p{scroll_bar[1]}};
        b = {bpp_p{scroll_bar[0]}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/hub75_pattern_gen.sv
// Animated test-pattern source with a frame-buffer style read port; 2-cycle read latency.
// o_rd_data packs segment s at bits [s*3*bpp_p +: 3*bpp_p] as {R, G, B}, R in the MSBs.
module hub75_pattern_gen
  import hub75_pkg::*;
#(
  parameter  int hpixel_p      = 64,
  parameter  int vpixel_p      = 64,
  parameter  int bpp_p         = 8,
  parameter  int segments_p    = 2,
  parameter  int frame_div_p   = 4,
  localparam int seg_lines_lp  = vpixel_p / segments_p,
  localparam int addr_width_lp = $clog2(hpixel_p * seg_lines_lp)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [2:0]                     i_mode,
  input  logic                           i_frame_start,
  input  logic                           i_rd_en,
  input  logic [addr_width_lp-1:0]       i_rd_addr,
  output logic [segments_p*3*bpp_p-1:0]  o_rd_data,
  output logic                           o_rd_valid
);

  localparam int col_w_lp   = $clog2(hpixel_p);
  localparam int lis_w_lp   = addr_width_lp - col_w_lp;
  localparam int line_w_lp  = $clog2(vpixel_p);
  localparam int presc_w_lp = (frame_div_p > 1) ? $clog2(frame_div_p) : 1;
  localparam int px_w_lp    = 3 * bpp_p;

  mode_e                 mode_q;
  logic [presc_w_lp-1:0] presc_q;
  logic [7:0]            anim_q;
  logic                  presc_wrap;

  logic [col_w_lp-1:0]   rd_col;
  logic [lis_w_lp-1:0]   rd_lis;

  mode_e                 mode_p1;
  logic [7:0]            anim_p1;
  logic [col_w_lp-1:0]   col_p1;
  logic [line_w_lp-1:0]  line_p1 [segments_p];
  logic                  vld_p1;

  logic [segments_p*px_w_lp-1:0] pix_data;

  // With frame_div_p == 1 the single prescaler bit stays 0, so every frame start wraps.
  assign presc_wrap = (presc_q == presc_w_lp'(frame_div_p - 1));
  assign rd_col     = i_rd_addr[col_w_lp-1:0];
  assign rd_lis     = i_rd_addr[addr_width_lp-1 -: lis_w_lp];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= OFF;
      presc_q <= '0;
      anim_q  <= '0;
    end else if (i_frame_start) begin
      mode_q  <= mode_e'(i_mode);
      presc_q <= presc_wrap ? '0 : presc_q + presc_w_lp'(1);
      if (presc_wrap) anim_q <= anim_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_p1    <= OFF;
      anim_p1    <= '0;
      col_p1     <= '0;
      vld_p1     <= 1'b0;
      for (int s = 0; s < segments_p; s++) line_p1[s] <= '0;
      o_rd_data  <= '0;
      o_rd_valid <= 1'b0;
    end else begin
      // stage 1: address, global lines, mode and anim as seen by this read
      mode_p1 <= mode_q;
      anim_p1 <= anim_q;
      col_p1  <= rd_col;
      vld_p1  <= i_rd_en;
      for (int s = 0; s < segments_p; s++)
        line_p1[s] <= line_w_lp'(s * seg_lines_lp) + line_w_lp'(rd_lis);
      // stage 2: pixel data, held between reads
      if (vld_p1) o_rd_data <= pix_data;
      o_rd_valid <= vld_p1;
    end
  end

  for (genvar s = 0; s < segments_p; s++) begin : g_seg
    hub75_pattern_pixel #(
      .bpp_p    (bpp_p),
      .col_w_p  (col_w_lp),
      .line_w_p (line_w_lp)
    ) u_pixel (
      .mode (mode_p1),
      .col  (col_p1),
      .line (line_p1[s]),
      .anim (anim_p1),
      .r    (pix_data[s*px_w_lp + 2*bpp_p +: bpp_p]),
      .g    (pix_data[s*px_w_lp +   bpp_p +: bpp_p]),
      .b    (pix_data[s*px_w_lp           +: bpp_p])
    );
  end

endmodule

// File: tb/tb_hub75_pattern_gen.sv
// Scoreboard bench for hub75_pattern_gen: stimulus pushes expected read data, a
// negedge monitor pops and compares whenever o_rd_valid is presented.
module tb_hub75_pattern_gen;

  localparam int HP        = 64;
  localparam int VP        = 64;
  localparam int BPP       = 8;
  localparam int SEG       = 2;
  localparam int FDIV      = 4;
  localparam int SEG_LINES = VP / SEG;
  localparam int COL_W     = $clog2(HP);
  localparam int LINE_W    = $clog2(VP);
  localparam int LIS_W     = $clog2(SEG_LINES);
  localparam int AW        = COL_W + LIS_W;
  localparam int PW        = 3 * BPP;
  localparam int DW        = SEG * PW;

  logic          clk;
  logic          rst_n;
  logic [2:0]    i_mode;
  logic          i_frame_start;
  logic          i_rd_en;
  logic [AW-1:0] i_rd_addr;
  logic [DW-1:0] o_rd_data;
  logic          o_rd_valid;

  hub75_pattern_gen #(
    .hpixel_p    (HP),
    .vpixel_p    (VP),
    .bpp_p       (BPP),
    .segments_p  (SEG),
    .frame_div_p (FDIV)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_mode        (i_mode),
    .i_frame_start (i_frame_start),
    .i_rd_en       (i_rd_en),
    .i_rd_addr     (i_rd_addr),
    .o_rd_data     (o_rd_data),
    .o_rd_valid    (o_rd_valid)
  );

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t          sb_q[$];
  int            cyc = 0;
  int            checks = 0;
  int            failures = 0;
  int            model_mode = 0;
  int            model_frames = 0;
  bit            done = 0;
  logic [DW-1:0] last_data;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: channel values straight from the pattern rules.
  function automatic int mscale(int v, int w);
    if (BPP >= w) return v * (1 << (BPP - w));
    return v / (1 << (w - BPP));
  endfunction

  function automatic logic [PW-1:0] model_pix(int mode, int col, int line, int anim);
    int full, r, g, b, c, bar;
    full = (1 << BPP) - 1;
    r = 0; g = 0; b = 0;
    case (mode)
      1: begin r = full; g = full; b = full; end
      2, 5: begin
        c   = (mode == 5) ? (col + anim) % HP : col;
        bar = c * 8 / HP;
        r = ((bar / 4) % 2 != 0) ? full : 0;
        g = ((bar / 2) % 2 != 0) ? full : 0;
        b = (bar % 2 != 0) ? full : 0;
      end
      3: begin
        r = mscale(col, COL_W);
        g = mscale(line, LINE_W);
        b = mscale(anim, 8);
      end
      4: if (((col / 8) + (line / 8) + anim) % 2 != 0) begin
        r = full; g = full; b = full;
      end
      default: ;
    endcase
    return {r[BPP-1:0], g[BPP-1:0], b[BPP-1:0]};
  endfunction

  function automatic logic [DW-1:0] model_read(int col, int lis);
    logic [DW-1:0] d;
    int anim;
    anim = (model_frames / FDIV) % 256;
    for (int s = 0; s < SEG; s++)
      d[s*PW +: PW] = model_pix(model_mode, col, s * SEG_LINES + lis, anim);
    return d;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle of stimulus; an explicit expected value overrides the model when use_exp is set.
  task automatic step(input bit fs, input int m, input bit rd, input int col, input int lis,
                      input bit use_exp, input logic [DW-1:0] exp);
    logic [DW-1:0] d;
    i_frame_start = fs;
    i_mode        = m[2:0];
    i_rd_en       = rd;
    i_rd_addr     = {lis[LIS_W-1:0], col[COL_W-1:0]};
    if (rd) begin
      d = use_exp ? exp : model_read(col, lis);
      sb_q.push_back('{d, cyc});
    end
    if (fs) begin
      model_mode = m;
      model_frames++;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor
  initial begin
    exp_t e;
    last_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("reset_valid", DW'(o_rd_valid), '0);
        chk("reset_data", o_rd_data, '0);
        last_data = '0;
      end else if (o_rd_valid) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_valid", DW'(o_rd_valid), '0);
        end else begin
          e = sb_q.pop_front();
          chk("rd_data", o_rd_data, e.data);
          chk("latency", DW'(cyc - e.cyc), DW'(2));
        end
        last_data = o_rd_data;
      end else begin
        chk("hold_data", o_rd_data, last_data);
      end
      if (done || cyc > 20000) begin
        chk("timeout", DW'(done), DW'(1));
        chk("drain", DW'(sb_q.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    end
  end

  // Stimulus
  initial begin
    rst_n = 1'b0;
    i_mode = '0;
    i_frame_start = 1'b0;
    i_rd_en = 1'b0;
    i_rd_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0, 0, '0);

    // OFF after reset, first reads
    for (int i = 0; i < 3; i++)
      step(0, 0, 1, $urandom_range(HP - 1), $urandom_range(SEG_LINES - 1), 0, '0);
    step(0, 0, 0, 0, 0, 0, '0);

    // BARS
    step(1, 2, 0, 0, 0, 0, '0);
    step(0, 2, 1, 8, 0, 1, 48'h0000FF_0000FF);
    step(0, 2, 1, 63, 0, 1, 48'hFFFFFF_FFFFFF);

    // GRAD at anim = 1
    for (int i = 0; i < 3; i++) step(1, 3, 0, 0, 0, 0, '0);
    step(0, 3, 1, 63, 5, 1, 48'hFC9401_FC1401);

    // Mode gating
    step(0, 1, 1, 10, 2, 0, '0);
    step(1, 1, 1, 20, 7, 0, '0);
    step(0, 1, 1, 30, 9, 1, 48'hFFFFFF_FFFFFF);

    // SCROLL at anim = 1
    step(1, 5, 0, 0, 0, 0, '0);
    step(0, 5, 1, 7, 0, 1, 48'h0000FF_0000FF);
    for (int i = 0; i < 8; i++)
      step(0, 5, 1, $urandom_range(HP - 1), $urandom_range(SEG_LINES - 1), 0, '0);

    // anim wraps back to 0, CHECKER
    while ((model_frames % (256 * FDIV)) >= FDIV) step(1, 4, 0, 0, 0, 0, '0);
    step(0, 4, 1, 8, 0, 1, 48'hFFFFFF_FFFFFF);
    for (int i = 0; i < 8; i++)
      step(0, 4, 1, $urandom_range(HP - 1), $urandom_range(SEG_LINES - 1), 0, '0);

    // Randomized traffic with random frame starts and modes
    for (int i = 0; i < 400; i++)
      step($urandom_range(7) == 0, $urandom_range(7), $urandom_range(3) != 0,
           $urandom_range(HP - 1), $urandom_range(SEG_LINES - 1), 0, '0);

    // Reset mid-stream with non-zero mode and anim
    step(1, 2, 0, 0, 0, 0, '0);
    for (int i = 0; i < FDIV && ((model_frames / FDIV) % 256) == 0; i++)
      step(1, 2, 0, 0, 0, 0, '0);
    step(0, 2, 1, 17, 3, 0, '0);
    i_rd_addr = {5'd4, 6'd40};
    #2;
    rst_n = 1'b0;
    sb_q.delete();
    model_mode = 0;
    model_frames = 0;
    i_rd_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(0, 5, 0, 0, 0, 0, '0);
    step(0, 5, 0, 0, 0, 0, '0);
    step(0, 5, 1, 63, 5, 1, 48'h000000_000000);
    step(1, 3, 0, 0, 0, 0, '0);
    step(0, 3, 1, 63, 5, 1, 48'hFC9400_FC1400);
    for (int i = 0; i < 4; i++) step(0, 3, 0, 0, 0, 0, '0);
    done = 1;
  end

endmodule
